// File: rtl/systolic_skew_feeder_if.sv
// Operand stream into the skew feeder and the skewed row/column outputs to the array.
// Port names follow the feeder's published pin list so the bus maps one-to-one onto it.
interface systolic_skew_feeder_if #(
   parameter int DBITS = 8,
   parameter int ROWS  = 2,
   parameter int COLS  = 2
) ();
   logic                   i_CLEAR;
   logic                   i_IN_VALID;
   logic                   o_IN_READY;
   logic [ROWS*DBITS-1:0]  i_IN_A;
   logic [COLS*DBITS-1:0]  i_IN_B;
   logic [ROWS*DBITS-1:0]  o_A;
   logic [ROWS-1:0]        o_A_VALID;
   logic [COLS*DBITS-1:0]  o_B;
   logic [COLS-1:0]        o_B_VALID;
   logic                   o_TILE_DONE;

   modport master (
      output i_CLEAR, i_IN_VALID, i_IN_A, i_IN_B,
      input  o_IN_READY, o_A, o_A_VALID, o_B, o_B_VALID, o_TILE_DONE
   );

   modport slave (
      input  i_CLEAR, i_IN_VALID, i_IN_A, i_IN_B,
      output o_IN_READY, o_A, o_A_VALID, o_B, o_B_VALID, o_TILE_DONE
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews K-beat operand tiles onto systolic array edges: lane r/c delayed r+1/c+1 edges.
// Ready held low while the longest lane drains after the K-th beat; tile_done marks its last output.
module systolic_skew_feeder #(
   parameter int DBITS = 8,
   parameter int ROWS  = 2,
   parameter int COLS  = 2,
   parameter int K     = 2
) (
   input  logic                  i_CLK,
   input  logic                  i_RSTN,
   systolic_skew_feeder_if.slave bus
);
   localparam int L  = (ROWS > COLS) ? ROWS : COLS;
   localparam int CW = $clog2(K + 1);
   localparam int DW = (L > 1) ? $clog2(L) : 1;
   localparam logic [CW-1:0] LAST_BEAT  = CW'(K - 1);
   localparam logic [DW-1:0] DRAIN_INIT = (L > 1) ? DW'(L - 2) : '0;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

   state_t          state;
   logic [CW-1:0]   beat_cnt;
   logic [DW-1:0]   drain_cnt;
   logic            ready;
   logic            done;
   logic            accept;

   logic [DBITS-1:0] a_dat [ROWS][ROWS];
   logic [ROWS-1:0]  a_vld [ROWS];
   logic [DBITS-1:0] b_dat [COLS][COLS];
   logic [COLS-1:0]  b_vld [COLS];
   logic [ROWS*DBITS-1:0] a_out;
   logic [ROWS-1:0]       a_out_vld;
   logic [COLS*DBITS-1:0] b_out;
   logic [COLS-1:0]       b_out_vld;

   assign accept = bus.i_IN_VALID & ready & ~bus.i_CLEAR;

   // Tile control: drain_cnt counts the cycles until the longest lane shows the last beat.
   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         ready     <= 1'b0;
         done      <= 1'b0;
      end else if (bus.i_CLEAR) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         ready     <= 1'b1;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, FEED: begin
               ready <= 1'b1;
               if (accept) begin
                  if (beat_cnt == LAST_BEAT) begin
                     if (L == 1) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        done     <= 1'b1;
                     end else begin
                        state     <= DRAIN;
                        beat_cnt  <= beat_cnt + CW'(1);
                        drain_cnt <= DRAIN_INIT;
                        ready     <= 1'b0;
                     end
                  end else begin
                     state    <= FEED;
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
                  ready    <= 1'b1;
                  done     <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   // Stage 0 captures zero data on bubbles, so a clear valid always travels with clear data.
   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         for (int r = 0; r < ROWS; r++) begin
            a_vld[r] <= '0;
            for (int s = 0; s < ROWS; s++) a_dat[r][s] <= '0;
         end
         for (int c = 0; c < COLS; c++) begin
            b_vld[c] <= '0;
            for (int s = 0; s < COLS; s++) b_dat[c][s] <= '0;
         end
      end else if (bus.i_CLEAR) begin
         for (int r = 0; r < ROWS; r++) begin
            a_vld[r] <= '0;
            for (int s = 0; s < ROWS; s++) a_dat[r][s] <= '0;
         end
         for (int c = 0; c < COLS; c++) begin
            b_vld[c] <= '0;
            for (int s = 0; s < COLS; s++) b_dat[c][s] <= '0;
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            a_vld[r][0] <= accept;
            a_dat[r][0] <= accept ? bus.i_IN_A[r*DBITS +: DBITS] : '0;
            for (int s = 1; s < ROWS; s++) begin
               if (s <= r) begin
                  a_vld[r][s] <= a_vld[r][s-1];
                  a_dat[r][s] <= a_dat[r][s-1];
               end
            end
         end
         for (int c = 0; c < COLS; c++) begin
            b_vld[c][0] <= accept;
            b_dat[c][0] <= accept ? bus.i_IN_B[c*DBITS +: DBITS] : '0;
            for (int s = 1; s < COLS; s++) begin
               if (s <= c) begin
                  b_vld[c][s] <= b_vld[c][s-1];
                  b_dat[c][s] <= b_dat[c][s-1];
               end
            end
         end
      end
   end

   always_comb begin
      a_out     = '0;
      a_out_vld = '0;
      for (int r = 0; r < ROWS; r++) begin
         a_out[r*DBITS +: DBITS] = a_dat[r][r];
         a_out_vld[r]            = a_vld[r][r];
      end
   end

   always_comb begin
      b_out     = '0;
      b_out_vld = '0;
      for (int c = 0; c < COLS; c++) begin
         b_out[c*DBITS +: DBITS] = b_dat[c][c];
         b_out_vld[c]            = b_vld[c][c];
      end
   end

   assign bus.o_A         = a_out;
   assign bus.o_A_VALID   = a_out_vld;
   assign bus.o_B         = b_out;
   assign bus.o_B_VALID   = b_out_vld;
   assign bus.o_IN_READY  = ready;
   assign bus.o_TILE_DONE = done;
endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter DBITS, default 8, sets the width of one operand element.
REQ-002 Parameter ROWS, default 2, sets the number of A lanes (array rows).
REQ-003 Parameter COLS, default 2, sets the number of B lanes (array columns).
REQ-004 Parameter K, default 2, sets the beats per tile (accumulation depth); legal range is K>=1.
REQ-005 Port i_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port i_RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port i_CLEAR, input, 1 bit: synchronous abort of the current tile.
REQ-008 Port i_IN_VALID, input, 1 bit: an upstream beat is present.
REQ-009 Port o_IN_READY, output, 1 bit: the feeder accepts a beat this cycle.
REQ-010 Port i_IN_A, input, ROWS*DBITS bits: one A column; element r at bits [(r+1)*DBITS-1 : r*DBITS].
REQ-011 Port i_IN_B, input, COLS*DBITS bits: one B row; element c at bits [(c+1)*DBITS-1 : c*DBITS].
REQ-012 Port o_A, output, ROWS*DBITS bits: skewed A data to the array row inputs.
REQ-013 Port o_A_VALID, output, ROWS bits: per-row valid for o_A.
REQ-014 Port o_B, output, COLS*DBITS bits: skewed B data to the array column inputs.
REQ-015 Port o_B_VALID, output, COLS bits: per-column valid for o_B.
REQ-016 Port o_TILE_DONE, output, 1 bit: one-cycle pulse marking the last skewed output of a tile.

Function
REQ-017 A beat SHALL be accepted on a rising edge only when i_IN_VALID=1, o_IN_READY=1 and i_CLEAR=0.
REQ-018 The element on A lane r of a beat accepted at edge e SHALL appear on o_A lane r, with o_A_VALID[r]=1, during the cycle after edge e+r (delay r+1).
REQ-019 The element on B lane c SHALL be delayed by c+1 edges in the same way on o_B/o_B_VALID.
REQ-020 Cycles with no accepted beat SHALL insert a bubble (valid=0) that travels down every lane.
REQ-021 Any lane whose valid is 0 SHALL drive data 0.
REQ-022 States: IDLE (no tile in progress), FEED (1..K-1 beats accepted), DRAIN (all K beats accepted, delay lines emptying).
REQ-023 IDLE->FEED on the first accepted beat when K>1.
REQ-024 FEED->DRAIN on the K-th accepted beat.
REQ-025 With K=1, the first accepted beat SHALL go IDLE->DRAIN directly.
REQ-026 A beat counter SHALL be $clog2(K+1) bits wide and count accepted beats; it clears when a tile finishes or is cleared.
REQ-027 Let L=max(ROWS,COLS). For a K-th accept at edge e, o_IN_READY SHALL be 0 for the L-1 cycles after edges e..e+L-2 and 1 again after edge e+L-1.
REQ-028 o_TILE_DONE SHALL be 1 only in the cycle after edge e+L-1; that cycle coincides with the last valid on lane L-1, and the state returns to IDLE.
REQ-029 When L=1, o_IN_READY SHALL never drop and o_TILE_DONE SHALL pulse in the cycle after edge e.
REQ-030 o_IN_READY SHALL be 1 in IDLE and FEED, independent of i_IN_VALID.
REQ-031 When i_CLEAR=1 at an edge, the block SHALL:
- zero all delay-line valids and data;
- zero the beat counter;
- enter IDLE with o_IN_READY=1;
- not assert o_TILE_DONE for the aborted tile.
REQ-032 If i_CLEAR and i_IN_VALID are both 1 at the same edge, clear SHALL win and the beat SHALL be dropped.

Reset
REQ-033 While i_RSTN=0, all of these SHALL be 0 immediately, without waiting for a clock edge: o_A, o_A_VALID, o_B, o_B_VALID, o_TILE_DONE, o_IN_READY, the beat counter and all delay-line registers. The state SHALL be IDLE.
REQ-034 o_IN_READY SHALL become 1 after the first rising edge following reset release.
REQ-035 Reset asserted mid-tile SHALL discard all in-flight data, and no o_TILE_DONE SHALL follow.

Verification
REQ-036 Defaults; beats A={0x02,0x01}/B={0x04,0x03} then A={0x12,0x11}/B={0x14,0x13} at edges 1,2 -> lane0 shows 0x01/0x03 after edge 1 and 0x11/0x13 after edge 2; lane1 shows 0x02/0x04 after edge 2 and 0x12/0x14 after edge 3; o_IN_READY=0 after edge 2 only; o_TILE_DONE=1 after edge 3.
REQ-037 Defaults; i_IN_VALID low for one cycle between beats 1 and 2 -> every lane shows one valid=0, data=0 bubble between the two elements; o_TILE_DONE appears one cycle later than in REQ-036.
REQ-038 ROWS=4, COLS=2, K=3, continuous valid -> o_IN_READY low for exactly 3 cycles; o_TILE_DONE coincides with o_A_VALID[3] of beat 3; next tile accepted with no gap after o_IN_READY rises.
REQ-039 i_CLEAR pulsed together with i_IN_VALID while in FEED -> that beat is dropped; all valids are 0 the next cycle; no o_TILE_DONE; a following full tile behaves exactly as in REQ-036.
REQ-040 i_RSTN dropped asynchronously mid-DRAIN -> all outputs read 0 before the next edge; after release, o_IN_READY rises after one edge and no stale valid appears.
REQ-041 ROWS=COLS=1, K=1, back-to-back beats -> o_IN_READY stays 1; each element is output after one edge; o_TILE_DONE pulses every cycle.
